// File: rtl/alu_decode_stage.sv
// RV32I decode/operand-issue stage: decodes OP, OP-IMM, LUI and AUIPC into ALU
// operands and opcode, held in a one-entry valid/ready pipeline register.
module alu_decode_stage #(
   parameter int XLEN = 32
) (
   input  logic            clk_i,
   input  logic            rstn_i,
   input  logic            instr_valid_i,
   output logic            instr_ready_o,
   input  logic [31:0]     instr_i,
   input  logic [XLEN-1:0] pc_i,
   input  logic            flush_i,
   output logic [4:0]      rs1_addr_o,
   output logic [4:0]      rs2_addr_o,
   input  logic [XLEN-1:0] rs1_data_i,
   input  logic [XLEN-1:0] rs2_data_i,
   output logic            valid_o,
   input  logic            ready_i,
   output logic [XLEN-1:0] alu_op1_o,
   output logic [XLEN-1:0] alu_op2_o,
   output logic [3:0]      alu_opcode_o,
   output logic [4:0]      rd_addr_o,
   output logic            rd_we_o,
   output logic            illegal_o,
   output logic [XLEN-1:0] pc_o
);

   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_XOR  = 4'd2,
      ALU_OR   = 4'd3,
      ALU_AND  = 4'd4,
      ALU_SLL  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_SLT  = 4'd8,
      ALU_SLTU = 4'd9
   } alu_op_e;

   localparam logic [6:0] OPC_OP    = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI   = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC = 7'b0010111;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   // Base-encoding funct3 to ALU op; SUB/SRA are resolved separately by funct7.
   function automatic alu_op_e f3_to_op(input logic [2:0] f3);
      case (f3)
         3'b000:  f3_to_op = ALU_ADD;
         3'b001:  f3_to_op = ALU_SLL;
         3'b010:  f3_to_op = ALU_SLT;
         3'b011:  f3_to_op = ALU_SLTU;
         3'b100:  f3_to_op = ALU_XOR;
         3'b101:  f3_to_op = ALU_SRL;
         3'b110:  f3_to_op = ALU_OR;
         default: f3_to_op = ALU_AND;
      endcase
   endfunction

   logic [6:0] opcode;
   logic [2:0] funct3;
   logic [6:0] funct7;
   logic [4:0] rd;

   assign opcode = instr_i[6:0];
   assign funct3 = instr_i[14:12];
   assign funct7 = instr_i[31:25];
   assign rd     = instr_i[11:7];

   assign rs1_addr_o = instr_i[19:15];
   assign rs2_addr_o = instr_i[24:20];

   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] shamt_imm;
   logic [XLEN-1:0] shamt_reg;

   assign imm_i     = {{(XLEN-12){instr_i[31]}}, instr_i[31:20]};
   assign imm_u     = {instr_i[31:12], 12'b0};
   assign shamt_imm = {{(XLEN-5){1'b0}}, instr_i[24:20]};
   assign shamt_reg = {{(XLEN-5){1'b0}}, rs2_data_i[4:0]};

   logic [XLEN-1:0] dec_op1;
   logic [XLEN-1:0] dec_op2;
   alu_op_e         dec_opc;
   logic            dec_legal;

   // NOTE: every output of this block gets a default first, so no path can
   // leave one unassigned and infer a latch.
   always_comb begin
      dec_op1   = '0;
      dec_op2   = '0;
      dec_opc   = ALU_ADD;
      dec_legal = 1'b0;

      case (opcode)
         OPC_OP: begin
            dec_op1 = rs1_data_i;
            dec_op2 = rs2_data_i;
            if (funct7 == F7_BASE) begin
               dec_legal = 1'b1;
               dec_opc   = f3_to_op(funct3);
            end else if (funct7 == F7_ALT && funct3 == 3'b000) begin
               dec_legal = 1'b1;
               dec_opc   = ALU_SUB;
            end else if (funct7 == F7_ALT && funct3 == 3'b101) begin
               dec_legal = 1'b1;
               dec_opc   = ALU_SRA;
            end
            // Execute shifts by the whole operand, so only the low five bits may pass.
            if (funct3 == 3'b001 || funct3 == 3'b101) begin
               dec_op2 = shamt_reg;
            end
         end

         OPC_OPIMM: begin
            dec_op1 = rs1_data_i;
            dec_op2 = imm_i;
            dec_opc = f3_to_op(funct3);
            case (funct3)
               3'b001: begin
                  dec_op2   = shamt_imm;
                  dec_legal = (funct7 == F7_BASE);
               end
               3'b101: begin
                  dec_op2 = shamt_imm;
                  if (funct7 == F7_BASE) begin
                     dec_legal = 1'b1;
                  end else if (funct7 == F7_ALT) begin
                     dec_legal = 1'b1;
                     dec_opc   = ALU_SRA;
                  end
               end
               default: dec_legal = 1'b1;
            endcase
         end

         OPC_LUI: begin
            dec_op2   = imm_u;
            dec_legal = 1'b1;
         end

         OPC_AUIPC: begin
            dec_op1   = pc_i;
            dec_op2   = imm_u;
            dec_legal = 1'b1;
         end

         default: ;
      endcase

      // Illegal entries travel downstream with neutral operands.
      if (!dec_legal) begin
         dec_op1 = '0;
         dec_op2 = '0;
         dec_opc = ALU_ADD;
      end
   end

   logic capture;

   assign instr_ready_o = !valid_o || ready_i;
   assign capture       = instr_valid_i && instr_ready_o && !flush_i;

   alu_op_e opc_q;

   assign alu_opcode_o = opc_q;

   // NOTE: state updates use non-blocking assignments so every register samples
   // pre-edge values and simulation order cannot change the result.
   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         // NOTE: payload registers are reset too, so outputs are all-zero out of
         // reset rather than X until the first capture.
         valid_o   <= 1'b0;
         alu_op1_o <= '0;
         alu_op2_o <= '0;
         opc_q     <= ALU_ADD;
         rd_addr_o <= '0;
         rd_we_o   <= 1'b0;
         illegal_o <= 1'b0;
         pc_o      <= '0;
      end else if (flush_i) begin
         valid_o <= 1'b0;
      end else if (capture) begin
         valid_o   <= 1'b1;
         alu_op1_o <= dec_op1;
         alu_op2_o <= dec_op2;
         opc_q     <= dec_opc;
         rd_addr_o <= rd;
         rd_we_o   <= dec_legal && (rd != 5'd0);
         illegal_o <= !dec_legal;
         pc_o      <= pc_i;
      end else if (ready_i) begin
         valid_o <= 1'b0;
      end
   end

endmodule
